load_store_unit: RTL and testbench

// - Initiator side of the core's data-memory interface: takes one load/store per handshake from the MEM stage,

---
 rtl/lsu_pkg.sv | 33 +++
 rtl/lsu_data_align.sv | 55 +++++
 rtl/load_store_unit.sv | 165 ++++++++++++++++
 tb/tb_load_store_unit.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Holds the FSM state encoding, funct3 codes and the access-size helper.
package lsu_pkg;

   localparam int DATA_WIDTH     = 64;
   localparam int LANES          = DATA_WIDTH / 8;
   localparam int LSU_ADDR_LIMIT = 1024;

   localparam logic [2:0] FUNCT3_LB  = 3'b000;
   localparam logic [2:0] FUNCT3_LH  = 3'b001;
   localparam logic [2:0] FUNCT3_LW  = 3'b010;
   localparam logic [2:0] FUNCT3_LD  = 3'b011;
   localparam logic [2:0] FUNCT3_LBU = 3'b100;
   localparam logic [2:0] FUNCT3_LHU = 3'b101;
   localparam logic [2:0] FUNCT3_LWU = 3'b110;
   localparam logic [2:0] FUNCT3_SB  = 3'b000;
   localparam logic [2:0] FUNCT3_SH  = 3'b001;
   localparam logic [2:0] FUNCT3_SW  = 3'b010;
   localparam logic [2:0] FUNCT3_SD  = 3'b011;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } lsu_state_e;

   // Access size in bytes (1/2/4/8) from the low two funct3 bits.
   function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
      return 4'd1 << funct3[1:0];
   endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Byte-lane steering for the load/store unit.
// Builds store masks/lanes over two words and merges/extends load beats.
module lsu_data_align
   import lsu_pkg::*;
(
   input  logic [2:0]            off_i,
   input  logic [2:0]            funct3_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [DATA_WIDTH-1:0] beat0_i,
   input  logic [DATA_WIDTH-1:0] beat1_i,
   output logic                  split_o,
   output logic [LANES-1:0]      be0_o,
   output logic [LANES-1:0]      be1_o,
   output logic [DATA_WIDTH-1:0] wd0_o,
   output logic [DATA_WIDTH-1:0] wd1_o,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [3:0]              nbytes;
   logic [5:0]              sh;
   logic [15:0]             m16;
   logic [127:0]            w128;
   logic [127:0]            rcat;
   logic [DATA_WIDTH-1:0]   r64;

   assign nbytes  = size_bytes(funct3_i);
   assign sh      = {off_i, 3'b000};
   assign split_o = ({1'b0, off_i} + nbytes) > 4'd8;

   assign m16   = ((16'd1 << nbytes) - 16'd1) << off_i;
   assign be0_o = m16[7:0];
   assign be1_o = m16[15:8];

   assign w128  = {64'd0, wdata_i} << sh;
   assign wd0_o = w128[63:0];
   assign wd1_o = w128[127:64];

   assign rcat  = {beat1_i, beat0_i};
   assign r64   = 64'(rcat >> sh);

   // Keep the low size bytes and extend according to the load type.
   always_comb begin
      rdata_o = r64;
      case (funct3_i)
         FUNCT3_LB:  rdata_o = {{56{r64[7]}}, r64[7:0]};
         FUNCT3_LH:  rdata_o = {{48{r64[15]}}, r64[15:0]};
         FUNCT3_LW:  rdata_o = {{32{r64[31]}}, r64[31:0]};
         FUNCT3_LBU: rdata_o = {56'd0, r64[7:0]};
         FUNCT3_LHU: rdata_o = {48'd0, r64[15:0]};
         FUNCT3_LWU: rdata_o = {32'd0, r64[31:0]};
         default:    rdata_o = r64;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store per handshake, split into
// at most two aligned word beats, with a single registered response.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned ADDR_LIMIT = LSU_ADDR_LIMIT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_we_i,
   input  logic [63:0]           req_addr_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   input  logic [2:0]            req_funct3_i,
   output logic                  resp_valid_o,
   output logic [DATA_WIDTH-1:0] resp_rdata_o,
   output logic                  resp_err_o,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [63:0]           mem_addr_o,
   output logic [LANES-1:0]      mem_be_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic                  mem_gnt_i,
   input  logic                  mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

   lsu_state_e            state_q;
   logic                  we_q;
   logic [63:0]           addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [2:0]            funct3_q;
   logic                  split_q;
   logic                  beat_q;
   logic [DATA_WIDTH-1:0] buf0_q;

   logic                  idle;
   logic [2:0]            al_off;
   logic [2:0]            al_f3;
   logic [DATA_WIDTH-1:0] al_wd;
   logic [DATA_WIDTH-1:0] al_b0;
   logic [DATA_WIDTH-1:0] al_b1;
   logic                  al_split;
   logic [LANES-1:0]      al_be0;
   logic [LANES-1:0]      al_be1;
   logic [DATA_WIDTH-1:0] al_wd0;
   logic [DATA_WIDTH-1:0] al_wd1;
   logic [DATA_WIDTH-1:0] al_rdata;
   logic [64:0]           span_end;
   logic                  illegal;
   logic                  oor;

   assign idle        = (state_q == S_IDLE);
   assign req_ready_o = idle;

   // In IDLE the aligner looks at the live request so beat 0 can be
   // registered on the accept edge; afterwards it uses the latch.
   assign al_off = idle ? req_addr_i[2:0] : addr_q[2:0];
   assign al_f3  = idle ? req_funct3_i    : funct3_q;
   assign al_wd  = idle ? req_wdata_i     : wdata_q;

   // The closing beat arrives live; an unsplit load has no upper beat.
   assign al_b0 = split_q ? buf0_q      : mem_rdata_i;
   assign al_b1 = split_q ? mem_rdata_i : '0;

   lsu_data_align u_align (
      .off_i    (al_off),
      .funct3_i (al_f3),
      .wdata_i  (al_wd),
      .beat0_i  (al_b0),
      .beat1_i  (al_b1),
      .split_o  (al_split),
      .be0_o    (al_be0),
      .be1_o    (al_be1),
      .wd0_o    (al_wd0),
      .wd1_o    (al_wd1),
      .rdata_o  (al_rdata)
   );

   assign span_end = {1'b0, req_addr_i}
                   + 65'(size_bytes(req_funct3_i)) - 65'd1;
   assign oor      = span_end >= 65'(ADDR_LIMIT);
   assign illegal  = req_we_i ? req_funct3_i[2]
                              : (req_funct3_i == 3'b111);

   // Access sequencer: latch, issue beats, collect data, respond.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         funct3_q     <= '0;
         split_q      <= 1'b0;
         beat_q       <= 1'b0;
         buf0_q       <= '0;
         resp_valid_o <= 1'b0;
         resp_rdata_o <= '0;
         resp_err_o   <= 1'b0;
         mem_req_o    <= 1'b0;
         mem_we_o     <= 1'b0;
         mem_addr_o   <= '0;
         mem_be_o     <= '0;
         mem_wdata_o  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               resp_valid_o <= 1'b0;
               if (req_valid_i) begin
                  we_q     <= req_we_i;
                  addr_q   <= req_addr_i;
                  wdata_q  <= req_wdata_i;
                  funct3_q <= req_funct3_i;
                  beat_q   <= 1'b0;
                  if (illegal || oor) begin
                     split_q      <= 1'b0;
                     resp_valid_o <= 1'b1;
                     resp_err_o   <= 1'b1;
                     resp_rdata_o <= '0;
                     state_q      <= S_RESP;
                  end else begin
                     split_q     <= al_split;
                     mem_req_o   <= 1'b1;
                     mem_we_o    <= req_we_i;
                     mem_addr_o  <= {req_addr_i[63:3], 3'b000};
                     mem_be_o    <= al_be0;
                     mem_wdata_o <= al_wd0;
                     state_q     <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               if (mem_gnt_i) begin
                  mem_req_o <= 1'b0;
                  state_q   <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (mem_rvalid_i) begin
                  if (split_q && !beat_q) begin
                     buf0_q      <= mem_rdata_i;
                     beat_q      <= 1'b1;
                     mem_req_o   <= 1'b1;
                     mem_addr_o  <= {addr_q[63:3] + 61'd1, 3'b000};
                     mem_be_o    <= al_be1;
                     mem_wdata_o <= al_wd1;
                     state_q     <= S_ISSUE;
                  end else begin
                     resp_valid_o <= 1'b1;
                     resp_err_o   <= 1'b0;
                     resp_rdata_o <= we_q ? '0 : al_rdata;
                     state_q      <= S_RESP;
                  end
               end
            end
            default: begin
               resp_valid_o <= 1'b0;
               state_q      <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: random-latency memory slave,
// byte-array reference model, directed corner cases and random traffic.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic        req_we_i = 1'b0;
   logic [63:0] req_addr_i = '0;
   logic [63:0] req_wdata_i = '0;
   logic [2:0]  req_funct3_i = '0;
   logic        resp_valid_o;
   logic [63:0] resp_rdata_o;
   logic        resp_err_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [63:0] mem_addr_o;
   logic [7:0]  mem_be_o;
   logic [63:0] mem_wdata_o;
   logic        mem_gnt_i = 1'b0;
   logic        mem_rvalid_i = 1'b0;
   logic [63:0] mem_rdata_i = '0;

   load_store_unit dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_we_i     (req_we_i),
      .req_addr_i   (req_addr_i),
      .req_wdata_i  (req_wdata_i),
      .req_funct3_i (req_funct3_i),
      .resp_valid_o (resp_valid_o),
      .resp_rdata_o (resp_rdata_o),
      .resp_err_o   (resp_err_o),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_be_o     (mem_be_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0] smem [0:1031];
   logic [7:0] ref_mem [0:1031];

   int          force_gnt = -1;
   int          force_rv = -1;
   bit          pend = 0;
   int          gnt_left = 0;
   int          rv_left = 0;
   int          p_addr = 0;
   int          req_cyc = 0;
   int          max_req_cyc = 0;
   bit          unstable = 0;
   bit          req_seen = 0;
   logic [63:0] h_addr, h_wdata;
   logic [7:0]  h_be;
   logic [63:0] beat_addr[$];
   logic [7:0]  beat_be[$];

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ref_load(input int a, input logic [2:0] f3);
      int n;
      logic [63:0] v;
      n = 1 << f3[1:0];
      v = '0;
      for (int i = 0; i < n; i++) v |= 64'(ref_mem[a+i]) << (8*i);
      if (!f3[2] && n < 8 && v[8*n-1]) v |= ~((64'd1 << (8*n)) - 64'd1);
      return v;
   endfunction

   function automatic bit ref_err(input bit we, input int a, input logic [2:0] f3);
      int n;
      n = 1 << f3[1:0];
      if (we && f3[2]) return 1'b1;
      if (!we && f3 == 3'b111) return 1'b1;
      return (a + n - 1) >= 1024;
   endfunction

   task automatic ref_store(input int a, input logic [63:0] wd, input logic [2:0] f3);
      int n;
      n = 1 << f3[1:0];
      for (int i = 0; i < n; i++) ref_mem[a+i] = wd[8*i +: 8];
   endtask

   // Memory slave: random grant delay, completion 1-3 cycles after grant.
   initial begin
      forever begin
         @(negedge clk);
         mem_gnt_i = 1'b0;
         mem_rvalid_i = 1'b0;
         if (rst) begin
            pend = 0;
            req_cyc = 0;
         end else begin
            if (pend) begin
               if (rv_left == 0) begin
                  mem_rvalid_i = 1'b1;
                  for (int i = 0; i < 8; i++) mem_rdata_i[8*i +: 8] = smem[p_addr+i];
                  pend = 0;
               end else rv_left--;
            end
            if (mem_req_o) begin
               req_seen = 1;
               if (req_cyc == 0) begin
                  h_addr = mem_addr_o;
                  h_be = mem_be_o;
                  h_wdata = mem_wdata_o;
                  gnt_left = (force_gnt >= 0) ? force_gnt : $urandom_range(0, 2);
               end else if (mem_addr_o !== h_addr || mem_be_o !== h_be ||
                            mem_wdata_o !== h_wdata) unstable = 1;
               req_cyc++;
               if (req_cyc > max_req_cyc) max_req_cyc = req_cyc;
               if (gnt_left == 0) begin
                  mem_gnt_i = 1'b1;
                  req_cyc = 0;
                  beat_addr.push_back(mem_addr_o);
                  beat_be.push_back(mem_be_o);
                  p_addr = int'(mem_addr_o[10:0]);
                  if (mem_we_o)
                     for (int i = 0; i < 8; i++)
                        if (mem_be_o[i]) smem[p_addr+i] = mem_wdata_o[8*i +: 8];
                  rv_left = (force_rv >= 0) ? force_rv : $urandom_range(0, 2);
                  pend = 1;
               end else gnt_left--;
            end
         end
      end
   end

   task automatic do_req(input bit we, input logic [63:0] a, input logic [63:0] wd,
                         input logic [2:0] f3, output logic [63:0] rd,
                         output logic err, output int lat, output bit rdy_low);
      int n;
      bit got;
      rd = '0; err = 1'b0; lat = 0; rdy_low = 1; got = 0;
      @(negedge clk);
      n = 0;
      while (!req_ready_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready_o) chk("ready_timeout", 64'd0, 64'd1);
      req_valid_i = 1'b1;
      req_we_i = we;
      req_addr_i = a;
      req_wdata_i = wd;
      req_funct3_i = f3;
      @(posedge clk);
      #1 req_valid_i = 1'b0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (resp_valid_o) begin
            lat = k; rd = resp_rdata_o; err = resp_err_o; got = 1;
            break;
         end
         if (req_ready_o) rdy_low = 0;
      end
      if (!got) chk("resp_timeout", 64'd0, 64'd1);
      else begin
         @(negedge clk);
         chk("resp_pulse", 64'(resp_valid_o), 64'd0);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ready"}, 64'(req_ready_o), 64'd1);
      chk({tag, "_rvalid"}, 64'(resp_valid_o), 64'd0);
      chk({tag, "_rdata"}, resp_rdata_o, 64'd0);
      chk({tag, "_err"}, 64'(resp_err_o), 64'd0);
      chk({tag, "_mreq"}, 64'(mem_req_o), 64'd0);
      chk({tag, "_mwe"}, 64'(mem_we_o), 64'd0);
      chk({tag, "_maddr"}, mem_addr_o, 64'd0);
      chk({tag, "_mbe"}, 64'(mem_be_o), 64'd0);
      chk({tag, "_mwdata"}, mem_wdata_o, 64'd0);
   endtask

   initial begin
      logic [63:0] rd, wd, exp;
      logic        er;
      int          lat, a, n, pulses;
      bit          rl, we;
      logic [2:0]  f3;

      for (int i = 0; i < 1032; i++) begin
         smem[i] = 8'($urandom);
         ref_mem[i] = smem[i];
      end
      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      rst = 1'b0;

      beat_addr.delete(); beat_be.delete();
      do_req(1, 64'h10, 64'h1122334455667788, 3'b011, rd, er, lat, rl);
      ref_store(16, 64'h1122334455667788, 3'b011);
      chk("sd_beats", 64'(beat_addr.size()), 64'd1);
      chk("sd_be", 64'(beat_be[0]), 64'hFF);
      chk("sd_rdata", rd, 64'd0);
      beat_addr.delete(); beat_be.delete();
      do_req(0, 64'h10, 64'd0, 3'b011, rd, er, lat, rl);
      chk("ld_beats", 64'(beat_addr.size()), 64'd1);
      chk("ld_be", 64'(beat_be[0]), 64'hFF);
      chk("ld_rdata", rd, 64'h1122334455667788);

      for (int i = 0; i < 8; i++) begin
         smem[32+i] = 8'h00;
         ref_mem[32+i] = 8'h00;
      end
      smem[36] = 8'hFF; ref_mem[36] = 8'hFF;
      smem[37] = 8'h80; ref_mem[37] = 8'h80;
      do_req(0, 64'h24, 64'd0, 3'b000, rd, er, lat, rl);
      chk("lb_neg", rd, 64'hFFFF_FFFF_FFFF_FFFF);
      do_req(0, 64'h24, 64'd0, 3'b100, rd, er, lat, rl);
      chk("lbu", rd, 64'hFF);
      do_req(0, 64'h24, 64'd0, 3'b001, rd, er, lat, rl);
      chk("lh_neg", rd, 64'hFFFF_FFFF_FFFF_80FF);

      beat_addr.delete(); beat_be.delete();
      do_req(1, 64'h1E, 64'hDEADBEEF, 3'b010, rd, er, lat, rl);
      ref_store(30, 64'hDEADBEEF, 3'b010);
      chk("sw_beats", 64'(beat_addr.size()), 64'd2);
      chk("sw_addr0", beat_addr[0], 64'h18);
      chk("sw_be0", 64'(beat_be[0]), 64'hC0);
      chk("sw_addr1", beat_addr[1], 64'h20);
      chk("sw_be1", 64'(beat_be[1]), 64'h03);
      beat_addr.delete(); beat_be.delete();
      do_req(0, 64'h1E, 64'd0, 3'b110, rd, er, lat, rl);
      chk("lwu_split", rd, 64'hDEADBEEF);
      chk("lwu_beats", 64'(beat_addr.size()), 64'd2);
      chk("lwu_ready_low", 64'(rl), 64'd1);

      req_seen = 0;
      do_req(0, 64'h3FC, 64'd0, 3'b011, rd, er, lat, rl);
      chk("oor_lat", 64'(lat), 64'd1);
      chk("oor_err", 64'(er), 64'd1);
      chk("oor_rdata", rd, 64'd0);
      chk("oor_no_mem", 64'(req_seen), 64'd0);

      force_gnt = 0; force_rv = 0;
      do_req(0, 64'h40, 64'd0, 3'b011, rd, er, lat, rl);
      chk("min_lat", 64'(lat), 64'd3);
      chk("min_lat_data", rd, ref_load(64, 3'b011));

      force_gnt = 5; force_rv = -1;
      max_req_cyc = 0; unstable = 0;
      wd = {$urandom, $urandom};
      do_req(1, 64'h4B, wd, 3'b010, rd, er, lat, rl);
      ref_store(75, wd, 3'b010);
      chk("gnt_hold_cycles", 64'(max_req_cyc), 64'd6);
      chk("gnt_hold_stable", 64'(unstable), 64'd0);

      force_gnt = 0; force_rv = 10;
      beat_addr.delete(); beat_be.delete();
      @(negedge clk);
      req_valid_i = 1'b1; req_we_i = 1'b0;
      req_addr_i = 64'h3; req_funct3_i = 3'b011;
      @(posedge clk);
      #1 req_valid_i = 1'b0;
      n = 0;
      while (beat_addr.size() < 2 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("rst_reach_beat1", 64'(beat_addr.size()), 64'd2);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk_reset_vals("midrst");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      force_gnt = -1; force_rv = -1;
      pulses = 0;
      repeat (15) begin
         @(negedge clk);
         if (resp_valid_o) pulses++;
      end
      chk("midrst_no_resp", 64'(pulses), 64'd0);
      do_req(0, 64'h3, 64'd0, 3'b011, rd, er, lat, rl);
      chk("post_rst_ld", rd, ref_load(3, 3'b011));

      for (int t = 0; t < 250; t++) begin
         we = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         a = $urandom_range(0, 1040);
         wd = {$urandom, $urandom};
         do_req(we, 64'(a), wd, f3, rd, er, lat, rl);
         if (ref_err(we, a, f3)) begin
            chk("rnd_err", 64'(er), 64'd1);
            chk("rnd_err_lat", 64'(lat), 64'd1);
            exp = '0;
         end else begin
            chk("rnd_err", 64'(er), 64'd0);
            if (we) begin
               ref_store(a, wd, f3);
               exp = '0;
            end else exp = ref_load(a, f3);
         end
         chk("rnd_rdata", rd, exp);
      end

      n = 0;
      for (int i = 0; i < 1024; i++) if (smem[i] !== ref_mem[i]) n++;
      chk("mem_image", 64'(n), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
